// File: rtl/keypad_pkg.sv
// Shared keypad definitions: matrix geometry, scan FSM states and code helpers.
// Also used by the 7-seg display path to render key legends.
package keypad_pkg;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } scan_state_t;

    // Lowest-numbered active-low row wins when several rows are pulled down.
    function automatic logic [1:0] first_low_row(input logic [ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!rows[r]) begin
                idx = 2'(r);
            end
        end
        return idx;
    endfunction

    function automatic logic [1:0] col_index(input logic [COLS-1:0] cols);
        logic [1:0] idx;
        case (cols)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Printed legend of a standard 4x4 pad as a hex digit; '*' shows as E, '#' as F.
    function automatic logic [3:0] key_legend(input logic [CODE_W-1:0] code);
        logic [3:0] digit;
        case (code)
            4'd0:    digit = 4'h1;
            4'd1:    digit = 4'h2;
            4'd2:    digit = 4'h3;
            4'd3:    digit = 4'hA;
            4'd4:    digit = 4'h4;
            4'd5:    digit = 4'h5;
            4'd6:    digit = 4'h6;
            4'd7:    digit = 4'hB;
            4'd8:    digit = 4'h7;
            4'd9:    digit = 4'h8;
            4'd10:   digit = 4'h9;
            4'd11:   digit = 4'hC;
            4'd12:   digit = 4'hE;
            4'd13:   digit = 4'h0;
            4'd14:   digit = 4'hF;
            default: digit = 4'hD;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running prescaler producing a one-cycle tick every SCAN_DIV clocks.
// Shared between the keypad scanner and the multiplexed display driver.
module scan_tick #(
    parameter int SCAN_DIV = 125000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotating active-low column drive, synchronized and
// debounced row sensing, and a single registered key event per press with valid/ack.
module keypad_scan #(
    parameter int SCAN_DIV     = 125000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held,
    output logic       overrun
);

    import keypad_pkg::*;

    localparam int CNT_W = (DEBOUNCE_CNT < 2) ? 1 : $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    scan_state_t      state, state_next;
    logic [3:0]       row_meta, row_s;
    logic [3:0]       col_next;
    logic [1:0]       cand_row, cand_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             tick;
    logic             accept;
    logic [3:0]       new_code;

    scan_tick #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    // The FSM only moves on ticks; "reaching" the debounce count is tested one
    // short of the limit so acceptance happens on the tick that would make it.
    always_comb begin
        state_next = state;
        col_next   = col_out;
        cand_next  = cand_row;
        cnt_next   = cnt;
        accept     = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (row_s == 4'hF) begin
                        col_next = {col_out[2:0], col_out[3]};
                    end else begin
                        cand_next = first_low_row(row_s);
                        cnt_next  = CNT_W'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            accept     = 1'b1;
                            state_next = PRESSED;
                        end else begin
                            state_next = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!row_s[cand_row]) begin
                        cnt_next = cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            accept     = 1'b1;
                            state_next = PRESSED;
                        end
                    end else begin
                        cnt_next   = '0;
                        col_next   = {col_out[2:0], col_out[3]};
                        state_next = SCAN;
                    end
                end
                PRESSED: begin
                    if (row_s == 4'hF) begin
                        cnt_next = CNT_W'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            col_next   = {col_out[2:0], col_out[3]};
                            state_next = SCAN;
                        end else begin
                            state_next = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (row_s == 4'hF) begin
                        cnt_next = cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            col_next   = {col_out[2:0], col_out[3]};
                            state_next = SCAN;
                        end
                    end else begin
                        state_next = PRESSED;
                    end
                end
                default: begin
                    state_next = SCAN;
                end
            endcase
        end
    end

    assign new_code = {cand_next, col_index(col_out)};
    assign key_held = (state == PRESSED) || (state == RELEASE);

    // A pending unacknowledged key is never overwritten; the newcomer is dropped and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta  <= 4'hF;
            row_s     <= 4'hF;
            col_out   <= 4'b1110;
            cand_row  <= 2'd0;
            cnt       <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            row_meta <= row_in;
            row_s    <= row_meta;
            col_out  <= col_next;
            cand_row <= cand_next;
            cnt      <= cnt_next;
            if (accept) begin
                if (!key_valid || key_ack) begin
                    key_code  <= new_code;
                    key_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (key_ack) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Scenario bench for keypad_scan with a switch-matrix keypad model and a
// press-level reference model for randomized press/ack sequences.
module tb_keypad_scan;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack = 1'b0;
    logic        key_held;
    logic        overrun;

    logic [15:0] keys = 16'h0;
    int          compared = 0;
    int          mismatched = 0;
    int          events = 0;
    logic        prev_valid = 1'b0;

    keypad_scan #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ack  (key_ack),
        .key_held (key_held),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Switch matrix: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_out[c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (key_valid === 1'b1 && prev_valid !== 1'b1) begin
            events++;
        end
        prev_valid = key_valid;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: time limit expired, got still running want finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_ack();
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_held(input logic level, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (key_held === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Returns on the first sample after col_out newly switches to column idx.
    task automatic wait_col(input int idx, output bit ok);
        logic [3:0] target;
        bit         seen_other;
        target      = 4'hF;
        target[idx] = 1'b0;
        seen_other  = 1'b0;
        ok          = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (col_out !== target) begin
                seen_other = 1'b1;
            end else if (seen_other) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        @(negedge clk);
        reset = 1'b1;
        step(3);
        compared++;
        if (col_out !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 ||
            key_held !== 1'b0 || overrun !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_values: got col=%b code=%0d valid=%b held=%b ovr=%b want col=1110 code=0 valid=0 held=0 ovr=0",
                     col_out, key_code, key_valid, key_held, overrun);
        end
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_col = 4'hF;
            exp_col[(k / SCAN_DIV) % 4] = 1'b0;
            compared++;
            if (col_out !== exp_col || key_valid !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL idle_rotation cycle %0d: got col=%b valid=%b want col=%b valid=0",
                         k, col_out, key_valid, exp_col);
            end
        end
    endtask

    task automatic test_press_ack();
        bit ok;
        int ev0;
        ev0  = events;
        keys = 16'h0200;
        wait_valid(60, ok);
        compared++;
        if (!ok || key_code !== 4'd9 || key_held !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL press_accept: got seen=%0d code=%0d held=%b want seen=1 code=9 held=1",
                     ok, key_code, key_held);
        end
        step(2);
        compared++;
        if (key_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL valid_holds: got %b want 1", key_valid);
        end
        pulse_ack();
        compared++;
        if (key_valid !== 1'b0 || key_held !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ack_clears: got valid=%b held=%b want valid=0 held=1", key_valid, key_held);
        end
        step(10);
        keys = 16'h0;
        step(5);
        compared++;
        if (key_held !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL held_during_release: got %b want 1", key_held);
        end
        wait_held(1'b0, 40, ok);
        compared++;
        if (!ok || events - ev0 != 1) begin
            mismatched++;
            $display("[TB] FAIL single_event: got released=%0d events=%0d want released=1 events=1",
                     ok, events - ev0);
        end
    endtask

    task automatic test_bounce();
        bit ok;
        int ev0;
        ev0 = events;
        wait_col(3, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL bounce_sync: got col=%b want fresh 0111", col_out);
        end
        keys = 16'h0008;
        step(4);
        keys = 16'h0;
        step(1);
        compared++;
        if (col_out !== 4'b0111) begin
            mismatched++;
            $display("[TB] FAIL bounce_frozen: got col=%b want 0111", col_out);
        end
        step(3);
        compared++;
        if (col_out !== 4'b1110) begin
            mismatched++;
            $display("[TB] FAIL bounce_resume: got col=%b want 1110", col_out);
        end
        step(4);
        compared++;
        if (col_out !== 4'b1101 || key_valid !== 1'b0 || key_held !== 1'b0 || events != ev0) begin
            mismatched++;
            $display("[TB] FAIL bounce_no_event: got col=%b valid=%b held=%b events=%0d want col=1101 valid=0 held=0 events=0",
                     col_out, key_valid, key_held, events - ev0);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        keys = 16'h0010;
        wait_valid(60, ok);
        compared++;
        if (!ok || key_code !== 4'd4) begin
            mismatched++;
            $display("[TB] FAIL overrun_first: got seen=%0d code=%0d want seen=1 code=4", ok, key_code);
        end
        keys = 16'h0;
        wait_held(1'b0, 40, ok);
        keys = 16'h8000;
        wait_held(1'b1, 60, ok);
        step(2);
        compared++;
        if (!ok || key_code !== 4'd4 || key_valid !== 1'b1 || overrun !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL overrun_set: got seen=%0d code=%0d valid=%b ovr=%b want seen=1 code=4 valid=1 ovr=1",
                     ok, key_code, key_valid, overrun);
        end
        pulse_ack();
        compared++;
        if (key_valid !== 1'b0 || overrun !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL overrun_sticky: got valid=%b ovr=%b want valid=0 ovr=1", key_valid, overrun);
        end
        keys = 16'h0;
        wait_held(1'b0, 40, ok);
    endtask

    task automatic test_ack_same_cycle();
        bit ok;
        do_reset();
        keys = 16'h1000;
        wait_valid(60, ok);
        compared++;
        if (!ok || key_code !== 4'd12) begin
            mismatched++;
            $display("[TB] FAIL same_cycle_first: got seen=%0d code=%0d want seen=1 code=12", ok, key_code);
        end
        keys = 16'h0;
        wait_held(1'b0, 40, ok);
        wait_col(2, ok);
        keys = 16'h0004;
        step(SCAN_DIV * DEBOUNCE_CNT - 1);
        compared++;
        if (!ok || key_valid !== 1'b1 || key_held !== 1'b0 || key_code !== 4'd12) begin
            mismatched++;
            $display("[TB] FAIL same_cycle_pre: got sync=%0d valid=%b held=%b code=%0d want sync=1 valid=1 held=0 code=12",
                     ok, key_valid, key_held, key_code);
        end
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        compared++;
        if (key_code !== 4'd2 || key_valid !== 1'b1 || overrun !== 1'b0 || key_held !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL same_cycle_load: got code=%0d valid=%b ovr=%b held=%b want code=2 valid=1 ovr=0 held=1",
                     key_code, key_valid, overrun, key_held);
        end
        keys = 16'h0;
        wait_held(1'b0, 40, ok);
        pulse_ack();
    endtask

    task automatic test_multi_and_reset();
        bit ok;
        int ev0;
        ev0  = events;
        keys = 16'h2020;
        wait_valid(60, ok);
        step(20);
        compared++;
        if (!ok || key_code !== 4'd5 || key_held !== 1'b1 || events - ev0 != 1) begin
            mismatched++;
            $display("[TB] FAIL multi_key: got seen=%0d code=%0d held=%b events=%0d want seen=1 code=5 held=1 events=1",
                     ok, key_code, key_held, events - ev0);
        end
        reset = 1'b1;
        keys  = 16'h0;
        @(negedge clk);
        reset = 1'b0;
        compared++;
        if (col_out !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 ||
            key_held !== 1'b0 || overrun !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_in_pressed: got col=%b code=%0d valid=%b held=%b ovr=%b want col=1110 code=0 valid=0 held=0 ovr=0",
                     col_out, key_code, key_valid, key_held, overrun);
        end
        ev0 = events;
        step(40);
        compared++;
        if (key_valid !== 1'b0 || events != ev0) begin
            mismatched++;
            $display("[TB] FAIL post_reset_quiet: got valid=%b events=%0d want valid=0 events=0",
                     key_valid, events - ev0);
        end
        keys = 16'h0800;
        wait_valid(60, ok);
        compared++;
        if (!ok || key_code !== 4'd11) begin
            mismatched++;
            $display("[TB] FAIL fresh_press: got seen=%0d code=%0d want seen=1 code=11", ok, key_code);
        end
        pulse_ack();
        keys = 16'h0;
        wait_held(1'b0, 40, ok);
    endtask

    // Presses are long and well separated, so each press yields exactly one accept;
    // the model only tracks whether the previous event is still unacknowledged.
    task automatic test_random_presses();
        int       ev0, m_events, code;
        logic     m_valid, m_overrun;
        logic [3:0] m_code;
        bit       do_ack;
        do_reset();
        ev0       = events;
        m_events  = 0;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        m_code    = 4'd0;
        for (int i = 0; i < 10; i++) begin
            code   = $urandom_range(3, 0) * 4 + $urandom_range(3, 0);
            do_ack = ($urandom_range(1, 0) == 1);
            keys   = 16'h0;
            keys[code] = 1'b1;
            step($urandom_range(80, 50));
            if (!m_valid) begin
                m_valid  = 1'b1;
                m_code   = 4'(code);
                m_events = m_events + 1;
            end else begin
                m_overrun = 1'b1;
            end
            compared++;
            if (key_code !== m_code || key_valid !== m_valid || overrun !== m_overrun || key_held !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL random_press %0d: got code=%0d valid=%b ovr=%b held=%b want code=%0d valid=%b ovr=%b held=1",
                         i, key_code, key_valid, overrun, key_held, m_code, m_valid, m_overrun);
            end
            if (do_ack) begin
                pulse_ack();
                m_valid = 1'b0;
            end
            keys = 16'h0;
            step($urandom_range(40, 25));
            compared++;
            if (key_held !== 1'b0 || key_valid !== m_valid) begin
                mismatched++;
                $display("[TB] FAIL random_release %0d: got held=%b valid=%b want held=0 valid=%b",
                         i, key_held, key_valid, m_valid);
            end
        end
        compared++;
        if (events - ev0 != m_events) begin
            mismatched++;
            $display("[TB] FAIL random_events: got %0d want %0d", events - ev0, m_events);
        end
    endtask

    initial begin
        test_reset();
        test_press_ack();
        test_bounce();
        test_overrun();
        test_ack_same_cycle();
        test_multi_and_reset();
        test_random_presses();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
